// File: rtl/arqui_ctrl_fsm_pkg.sv
// Shared definitions for the arqui control block: state encodings,
// FIFO bit positions in the status vectors and default threshold values.
package arqui_ctrl_fsm_pkg;

    // One-hot state encoding, also driven directly onto state_out.
    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_e;

    // Bit positions inside fifo_empty / fifo_error / error_out.
    localparam int FIFO_MAIN = 0;
    localparam int FIFO_VC0  = 1;
    localparam int FIFO_VC1  = 2;
    localparam int FIFO_D0   = 3;
    localparam int FIFO_D1   = 4;

    // Recommended thresholds for software bring-up (almost-empty / almost-full).
    localparam logic [1:0] DEF_AE_MF = 2'b01;
    localparam logic [1:0] DEF_AF_MF = 2'b11;
    localparam logic [3:0] DEF_AE_VC = 4'b0010;
    localparam logic [3:0] DEF_AF_VC = 4'b1110;
    localparam logic [1:0] DEF_AE_DF = 2'b01;
    localparam logic [1:0] DEF_AF_DF = 2'b11;

endpackage

// File: rtl/arqui_ctrl_fsm_cfg_regs.sv
// Threshold register bank: loads the requested almost-full/almost-empty
// values while load is high and freezes them otherwise. Also reports whether
// the requested set is self-consistent (every almost-full above its
// almost-empty).
module arqui_cfg_regs
    import arqui_ctrl_fsm_pkg::*;
#(
    parameter int MF_AW = 2,
    parameter int VC_AW = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             load,
    input  logic [MF_AW-1:0] af_mf_i,
    input  logic [MF_AW-1:0] ae_mf_i,
    input  logic [VC_AW-1:0] af_vc_i,
    input  logic [VC_AW-1:0] ae_vc_i,
    input  logic [MF_AW-1:0] af_df_i,
    input  logic [MF_AW-1:0] ae_df_i,
    output logic [MF_AW-1:0] af_mf_o,
    output logic [MF_AW-1:0] ae_mf_o,
    output logic [VC_AW-1:0] af_vc_o,
    output logic [VC_AW-1:0] ae_vc_o,
    output logic [MF_AW-1:0] af_df_o,
    output logic [MF_AW-1:0] ae_df_o,
    output logic             cfg_ok
);

    logic [MF_AW-1:0] af_mf_q, af_mf_d;
    logic [MF_AW-1:0] ae_mf_q, ae_mf_d;
    logic [VC_AW-1:0] af_vc_q, af_vc_d;
    logic [VC_AW-1:0] ae_vc_q, ae_vc_d;
    logic [MF_AW-1:0] af_df_q, af_df_d;
    logic [MF_AW-1:0] ae_df_q, ae_df_d;

    // Follow the requested values while loading, hold them otherwise.
    always_comb begin
        af_mf_d = af_mf_q;
        ae_mf_d = ae_mf_q;
        af_vc_d = af_vc_q;
        ae_vc_d = ae_vc_q;
        af_df_d = af_df_q;
        ae_df_d = ae_df_q;
        if (load) begin
            af_mf_d = af_mf_i;
            ae_mf_d = ae_mf_i;
            af_vc_d = af_vc_i;
            ae_vc_d = ae_vc_i;
            af_df_d = af_df_i;
            ae_df_d = ae_df_i;
        end
    end

    // Threshold storage, cleared to zero on reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            af_mf_q <= '0;
            ae_mf_q <= '0;
            af_vc_q <= '0;
            ae_vc_q <= '0;
            af_df_q <= '0;
            ae_df_q <= '0;
        end else begin
            af_mf_q <= af_mf_d;
            ae_mf_q <= ae_mf_d;
            af_vc_q <= af_vc_d;
            ae_vc_q <= ae_vc_d;
            af_df_q <= af_df_d;
            ae_df_q <= ae_df_d;
        end
    end

    // The check looks at the live request, since that is what gets latched
    // on the edge that leaves configuration.
    assign cfg_ok = (af_mf_i > ae_mf_i) && (af_vc_i > ae_vc_i) && (af_df_i > ae_df_i);

    assign af_mf_o = af_mf_q;
    assign ae_mf_o = ae_mf_q;
    assign af_vc_o = af_vc_q;
    assign ae_vc_o = ae_vc_q;
    assign af_df_o = af_df_q;
    assign ae_df_o = ae_df_q;

endmodule

// File: rtl/arqui_ctrl_fsm.sv
// Main control FSM for the arqui datapath. Walks RESET -> INIT -> IDLE/ACTIVE,
// traps into a sticky ERROR state on any FIFO fault, and publishes all status
// as registers that already reflect the state being entered.
module arqui_ctrl_fsm
    import arqui_ctrl_fsm_pkg::*;
#(
    parameter int MF_AW  = 2,
    parameter int VC_AW  = 4,
    parameter int N_FIFO = 5
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [MF_AW-1:0]  afMF_i,
    input  logic [MF_AW-1:0]  aeMF_i,
    input  logic [VC_AW-1:0]  afVC_i,
    input  logic [VC_AW-1:0]  aeVC_i,
    input  logic [MF_AW-1:0]  afDF_i,
    input  logic [MF_AW-1:0]  aeDF_i,
    input  logic [N_FIFO-1:0] fifo_empty,
    input  logic [N_FIFO-1:0] fifo_error,
    output logic [MF_AW-1:0]  afMF_o,
    output logic [MF_AW-1:0]  aeMF_o,
    output logic [VC_AW-1:0]  afVC_o,
    output logic [VC_AW-1:0]  aeVC_o,
    output logic [MF_AW-1:0]  afDF_o,
    output logic [MF_AW-1:0]  aeDF_o,
    output logic [4:0]        state_out,
    output logic [N_FIFO-1:0] error_out,
    output logic              idle_out,
    output logic              active_out,
    output logic              cfg_err_out
);

    state_e state_q, state_d;

    logic [N_FIFO-1:0] error_q, error_d;
    logic              idle_q, idle_d;
    logic              active_q, active_d;
    logic              cfg_err_q, cfg_err_d;

    logic cfg_ok;
    logic any_error;
    logic all_empty;

    assign any_error = |fifo_error;
    assign all_empty = &fifo_empty;

    // Thresholds are only writable while sitting in INIT.
    arqui_cfg_regs #(
        .MF_AW (MF_AW),
        .VC_AW (VC_AW)
    ) u_cfg_regs (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (state_q == ST_INIT),
        .af_mf_i (afMF_i),
        .ae_mf_i (aeMF_i),
        .af_vc_i (afVC_i),
        .ae_vc_i (aeVC_i),
        .af_df_i (afDF_i),
        .ae_df_i (aeDF_i),
        .af_mf_o (afMF_o),
        .ae_mf_o (aeMF_o),
        .af_vc_o (afVC_o),
        .ae_vc_o (aeVC_o),
        .af_df_o (afDF_o),
        .ae_df_o (aeDF_o),
        .cfg_ok  (cfg_ok)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a FIFO fault beats init, which beats everything else.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (any_error)   state_d = ST_ERROR;
                else if (init)   state_d = ST_INIT;
                else if (cfg_ok) state_d = ST_IDLE;
                else             state_d = ST_INIT;
            end
            ST_IDLE: begin
                if (any_error)       state_d = ST_ERROR;
                else if (init)       state_d = ST_INIT;
                else if (!all_empty) state_d = ST_ACTIVE;
                else                 state_d = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (any_error)      state_d = ST_ERROR;
                else if (init)      state_d = ST_INIT;
                else if (all_empty) state_d = ST_IDLE;
                else                state_d = ST_ACTIVE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    // Status outputs, computed from the state about to be entered so the
    // registered values line up with state_out on the same edge.
    always_comb begin
        error_d   = error_q;
        cfg_err_d = cfg_err_q;
        idle_d    = (state_d == ST_IDLE);
        active_d  = (state_d == ST_ACTIVE);
        if (state_q != ST_RESET) begin
            error_d = error_q | fifo_error;
        end
        if ((state_q == ST_INIT) && !any_error && !init) begin
            cfg_err_d = !cfg_ok;
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_q   <= '0;
            idle_q    <= 1'b0;
            active_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            error_q   <= error_d;
            idle_q    <= idle_d;
            active_q  <= active_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign state_out   = state_q;
    assign error_out   = error_q;
    assign idle_out    = idle_q;
    assign active_out  = active_q;
    assign cfg_err_out = cfg_err_q;

endmodule

// File: doc/arqui_ctrl_fsm.md
Name: arqui_ctrl_fsm

Overview:
- Main control state machine for the arqui datapath: Main FIFO -> VC0/VC1 FIFOs -> D0/D1 FIFOs.
- Sequences RESET -> INIT -> IDLE/ACTIVE, with a sticky ERROR state.
- Captures and validates the almost-full/almost-empty thresholds, then distributes them to the FIFOs as frozen registers.
- Reports idle, active, per-FIFO error and configuration-error status to the probador/checker.

Parameters:
MF_AW, 2, Main FIFO and D FIFO threshold width (depth 4)
VC_AW, 4, VC FIFO threshold width (depth 16)
N_FIFO, 5, number of monitored FIFOs (bit0 Main, bit1 VC0, bit2 VC1, bit3 D0, bit4 D1)

Ports:
clk  in  1  single system clock; all state updates on posedge
reset_L  in  1  asynchronous, active-low reset
init  in  1  request (re)configuration
afMF_i, aeMF_i  in  MF_AW  Main FIFO almost-full / almost-empty request
afVC_i, aeVC_i  in  VC_AW  VC FIFO almost-full / almost-empty request
afDF_i, aeDF_i  in  MF_AW  D FIFO almost-full / almost-empty request
fifo_empty  in  N_FIFO  empty flags, bit map as above
fifo_error  in  N_FIFO  overflow/underflow pulses, bit map as above
afMF_o, aeMF_o  out  MF_AW  registered Main FIFO thresholds
afVC_o, aeVC_o  out  VC_AW  registered VC FIFO thresholds
afDF_o, aeDF_o  out  MF_AW  registered D FIFO thresholds
state_out  out  5  one-hot state
error_out  out  N_FIFO  sticky per-FIFO error
idle_out  out  1  datapath idle
active_out  out  1  datapath busy
cfg_err_out  out  1  last INIT exit attempt rejected

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=RESET (5'b00001).
  - All threshold outputs, error_out, idle_out, active_out and cfg_err_out = 0.
- State encoding (one-hot): RESET 00001, INIT 00010, IDLE 00100, ACTIVE 01000, ERROR 10000.
- All outputs are registered: every output reflects the state entered at the same clock edge, with no combinational path from inputs to outputs.
- RESET: always goes to INIT on the first posedge after reset_L deasserts.
- INIT:
  - Each cycle, copy all six *_i into their *_o registers.
  - init=1: stay in INIT.
  - init=0: evaluate cfg_ok = (afMF_i>aeMF_i) && (afVC_i>aeVC_i) && (afDF_i>aeDF_i), unsigned compare on the current-cycle inputs.
    - cfg_ok=1: go to IDLE and clear cfg_err_out.
    - cfg_ok=0: stay in INIT and set cfg_err_out=1.
- Threshold outputs are frozen in every state other than INIT; changes on *_i are ignored there.
- IDLE (idle_out=1, active_out=0):
  - Any fifo_empty bit = 0: go to ACTIVE.
  - Otherwise stay in IDLE.
- ACTIVE (active_out=1, idle_out=0):
  - fifo_empty all ones: go to IDLE.
- init=1 in IDLE or ACTIVE: go to INIT. The current thresholds are kept until INIT overwrites them on the next edge.
- ERROR:
  - Any fifo_error bit ≠ 0 in INIT, IDLE or ACTIVE: go to ERROR.
  - error_out |= fifo_error on that same edge, so the offending bits are visible on entry.
  - In ERROR: error_out keeps accumulating (OR), idle_out=active_out=0.
  - Exit from ERROR is only via reset_L; init is ignored.
- Transition priority within a cycle: fifo_error > init > cfg check / empty-based transitions.
- fifo_error is ignored in RESET.
- Single-cycle fifo_error pulses must be caught. There is no debounce; the input is sampled every edge.
- Reset asserted mid-operation: immediate return to RESET values, no flush handshake with the FIFOs required.

Decomposition:
- Shared package/header holds:
  - the state encodings (ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR);
  - FIFO bit indices (FIFO_MAIN=0, FIFO_VC0=1, FIFO_VC1=2, FIFO_D0=3, FIFO_D1=4);
  - default threshold constants (MF 01/11, VC 0010/1110, DF 01/11).
- One sub-module is natural: arqui_cfg_regs, which holds the six threshold registers plus the cfg_ok compare.
- The FSM holds next-state logic and the status registers.

Test Plan:
- Reset then 1 cycle: state_out=00001 -> 00010. Hold init=1 with aeMF=01, afMF=11, aeVC=0010, afVC=1110, aeDF=01, afDF=11. Drop init -> next edge IDLE, idle_out=1, thresholds on *_o match.
- Bad config: init drops with aeVC_i=1110, afVC_i=0010 -> stays INIT, cfg_err_out=1. Fix to 0010/1110 -> IDLE, cfg_err_out=0.
- From IDLE, fifo_empty=11101 -> ACTIVE next edge, active_out=1. fifo_empty=11111 -> IDLE. After IDLE, change afMF_i=10 -> afMF_o stays 11.
- In ACTIVE, pulse fifo_error=01000 for 1 cycle -> ERROR, error_out=01000. Then fifo_error=00001 -> error_out=01001. init=1 ignored. reset_L=0 -> all outputs 0.
- Same cycle fifo_error=00010 and init=1 in IDLE -> ERROR (error priority), error_out=00010.
- init=1 while ACTIVE with new afVC_i=1100 -> INIT, afVC_o=1100 one edge later. Assert reset_L=0 mid-INIT -> asynchronous clear of all outputs.
